block_accum: RTL and testbench

//  Streaming block accumulator: sums LEN consecutive signed 8-bit samples into one

---
 rtl/block_accum.sv | 107 ++++++++++
 tb/tb_block_accum.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/block_accum.sv
// block_accum: streaming block accumulator.
// Sums LEN consecutive signed IN_W-bit samples into one signed OUT_W-bit result.
// Valid/ready on both sides. A result stays in the output holding register until
// the consumer takes it, and the input stalls while that result is pending.
// Optional build macro BLOCK_ACCUM_SAT_EN: saturating accumulation. When it is
// undefined, the sum wraps modulo 2^OUT_W. out_ovf reports overflow in both builds.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds data stable while valid && !ready. out_data/out_ovf
// change only when a block completes.
module block_accum #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_acc;

  logic [OUT_W-1:0] sample_ext;
  logic [OUT_W-1:0] sum_wrap;
  logic [OUT_W-1:0] sum;
  logic             this_ovf;
  logic             accept;
  logic             block_end;

  // The whole input stalls while an untaken result is held.
  assign in_ready  = ~(out_valid & ~out_ready);
  assign accept    = in_valid & in_ready;
  assign block_end = accept & (cnt == LAST);

  // Sign-extend the sample, add, and detect signed overflow. Overflow means both
  // operands have the same sign and the sum has the other sign.
  always_comb begin
    sample_ext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
    sum_wrap   = acc + sample_ext;
    this_ovf   = (acc[OUT_W-1] == sample_ext[OUT_W-1]) &&
                 (sum_wrap[OUT_W-1] != acc[OUT_W-1]);
`ifdef BLOCK_ACCUM_SAT_EN
    // Clamp toward the sign of the operands. Later opposite-sign samples then
    // add normally from the clamped value.
    if (this_ovf) begin
      sum = acc[OUT_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      sum = sum_wrap;
    end
`else
    sum = sum_wrap;
`endif
  end

  // Accumulator, sample counter and sticky overflow for the block in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (accept) begin
      if (block_end) begin
        acc     <= '0;
        cnt     <= '0;
        ovf_acc <= 1'b0;
      end else begin
        acc     <= sum;
        cnt     <= cnt + CNT_W'(1);
        ovf_acc <= ovf_acc | this_ovf;
      end
    end
  end

  // Output holding register. A block end on the same edge as a take keeps
  // out_valid high with new data, so back-to-back blocks have no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (block_end) begin
      out_valid <= 1'b1;
      out_data  <= sum;
      out_ovf   <= ovf_acc | this_ovf;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // SAT_MAX/SAT_MIN are used only in the saturating build.
  logic unused_sat;
  assign unused_sat = ^{SAT_MAX, SAT_MIN};

endmodule

// File: tb/tb_block_accum.sv
// Testbench for block_accum. It instantiates LEN=4, LEN=300 and LEN=2 instances,
// driven one at a time. Expected results are pushed into per-instance queues,
// and a monitor pops them on each output handshake.
module tb_block_accum;

  logic clk;
  logic rst;

  logic        v[3];
  logic        rdy[3];
  logic [7:0]  d[3];
  logic        ov[3];
  logic        ordy[3];
  logic [15:0] od[3];
  logic        oo[3];

  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];
  logic [16:0] exp_q2[$];

  int checks = 0;
  int errors = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  block_accum #(.IN_W(8), .OUT_W(16), .LEN(4)) u_len4 (
    .clk(clk), .rst(rst), .in_valid(v[0]), .in_ready(rdy[0]), .in_data(d[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_ovf(oo[0])
  );

  block_accum #(.IN_W(8), .OUT_W(16), .LEN(300)) u_len300 (
    .clk(clk), .rst(rst), .in_valid(v[1]), .in_ready(rdy[1]), .in_data(d[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_ovf(oo[1])
  );

  block_accum #(.IN_W(8), .OUT_W(16), .LEN(2)) u_len2 (
    .clk(clk), .rst(rst), .in_valid(v[2]), .in_ready(rdy[2]), .in_data(d[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_ovf(oo[2])
  );

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%05h required=0x%05h", name, act, req);
    end
  endtask

  // Scoreboard monitor: pop and compare on each output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov[0] && ordy[0]) begin
        if (exp_q0.size() == 0) check("len4_unexpected", {oo[0], od[0]}, 17'h1ffff);
        else check("len4_result", {oo[0], od[0]}, exp_q0.pop_front());
      end
      if (ov[1] && ordy[1]) begin
        if (exp_q1.size() == 0) check("len300_unexpected", {oo[1], od[1]}, 17'h1ffff);
        else check("len300_result", {oo[1], od[1]}, exp_q1.pop_front());
      end
      if (ov[2] && ordy[2]) begin
        if (exp_q2.size() == 0) check("len2_unexpected", {oo[2], od[2]}, 17'h1ffff);
        else check("len2_result", {oo[2], od[2]}, exp_q2.pop_front());
      end
    end
  end

  // Driver: present one sample and hold it until accepted. The wait is bounded.
  task automatic send(input int k, input logic [7:0] dat, input bit must_be_ready);
    int guard;
    guard = 0;
    v[k] = 1'b1;
    d[k] = dat;
    @(negedge clk);
    if (must_be_ready) check("in_ready_high", {16'd0, rdy[k]}, 17'd1);
    while (!rdy[k] && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!rdy[k]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout inst=%0d actual=in_ready_low required=accept", k);
    end
    @(posedge clk);
    #1;
    v[k] = 1'b0;
  endtask

  task automatic pulse_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b0;
      d[k] = 8'd0;
      ordy[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    pulse_reset(2);

    // reset state
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", {16'd0, ov[k]}, 17'd0);
      check("rst_out_data",  {1'b0, od[k]}, 17'd0);
      check("rst_out_ovf",   {16'd0, oo[k]}, 17'd0);
      check("rst_in_ready",  {16'd0, rdy[k]}, 17'd1);
    end
    @(posedge clk);
    #1;

    // 1: 10+20+30+40 = 100
    exp_q0.push_back({1'b0, 16'h0064});
    send(0, 8'd10, 1'b1);
    send(0, 8'd20, 1'b1);
    send(0, 8'd30, 1'b1);
    send(0, 8'd40, 1'b1);
    @(negedge clk);
    check("t1_valid_latency", {16'd0, ov[0]}, 17'd1);
    @(posedge clk);
    #1;

    // 2: -128 x4 = -512
    exp_q0.push_back({1'b0, 16'hFE00});
    for (int i = 0; i < 4; i++) send(0, 8'h80, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // 3: stall the held result; the input must stall too
    exp_q0.push_back({1'b0, 16'h0064});
    exp_q0.push_back({1'b0, 16'h000A});
    ordy[0] = 1'b0;
    send(0, 8'd10, 1'b0);
    send(0, 8'd20, 1'b0);
    send(0, 8'd30, 1'b0);
    send(0, 8'd40, 1'b0);
    fork
      begin
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("t3_in_ready_low", {16'd0, rdy[0]}, 17'd0);
          check("t3_held_data", {oo[0], od[0]}, {1'b0, 16'h0064});
          check("t3_held_valid", {16'd0, ov[0]}, 17'd1);
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        @(negedge clk);
        check("t3_in_ready_release", {16'd0, rdy[0]}, 17'd1);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // 5: a partial block (the leftover 5, then 5, 5) is discarded by reset
    send(0, 8'd5, 1'b0);
    send(0, 8'd5, 1'b0);
    pulse_reset(1);
    exp_q0.push_back({1'b0, 16'h0004});
    for (int i = 0; i < 4; i++) send(0, 8'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // 4: LEN=300, 127 x300 overflows OUT_W
`ifdef BLOCK_ACCUM_SAT_EN
    exp_q1.push_back({1'b1, 16'h7FFF});
`else
    exp_q1.push_back({1'b1, 16'h94D4});
`endif
    for (int i = 0; i < 300; i++) send(1, 8'd127, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // 6: LEN=2 back-to-back, in_ready never drops
    exp_q2.push_back({1'b0, 16'd3});
    exp_q2.push_back({1'b0, 16'd7});
    send(2, 8'd1, 1'b1);
    send(2, 8'd2, 1'b1);
    send(2, 8'd3, 1'b1);
    send(2, 8'd4, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // every expected result must have been seen
    check("len4_queue_empty",   17'(exp_q0.size()), 17'd0);
    check("len300_queue_empty", 17'(exp_q1.size()), 17'd0);
    check("len2_queue_empty",   17'(exp_q2.size()), 17'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
